// File: rtl/game_sequencer.sv
// Flappy Bird game controller: button conditioning, IDLE/PLAY/DEAD sequencing,
// once-per-frame collision/floor check and saturating 4-digit BCD score.

module game_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          s1_q, s2_q, acc_q, acc_prev_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronized level disagrees with the accepted one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      acc_prev_q <= acc_q;
      if (s2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        acc_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = acc_q & ~acc_prev_q;
endmodule

module game_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BIRD_SIZE       = 20,
  parameter int PIPE_WIDTH      = 60,
  parameter int GAP_HEIGHT      = 120,
  parameter int FLOOR_Y         = 460
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnStart,
  input  logic        BtnFlap,
  input  logic        FrameTick,
  input  logic [9:0]  BirdX,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  PipeX,
  input  logic [9:0]  PipeY,
  output logic        Start,
  output logic        Flap,
  output logic        Running,
  output logic        Lost,
  output logic [15:0] Score,
  output logic [1:0]  State
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DEAD = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic        passed_q, passed_d;
  logic        flap_q, running_q, lost_q;
  logic        start_press, flap_press;

  game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk_i(Clk), .rst_ni(Reset), .btn_i(BtnStart), .press_o(start_press)
  );
  game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_flap (
    .clk_i(Clk), .rst_ni(Reset), .btn_i(BtnFlap), .press_o(flap_press)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 11-bit geometry so that edge sums never wrap
  logic [10:0] bx, by, px, py, bird_r, bird_b, pipe_r, gap_b;
  logic        x_ov, hit, scored, respawn;

  assign bx      = {1'b0, BirdX};
  assign by      = {1'b0, BirdY};
  assign px      = {1'b0, PipeX};
  assign py      = {1'b0, PipeY};
  assign bird_r  = bx + 11'(BIRD_SIZE);
  assign bird_b  = by + 11'(BIRD_SIZE);
  assign pipe_r  = px + 11'(PIPE_WIDTH);
  assign gap_b   = py + 11'(GAP_HEIGHT);
  assign x_ov    = (bird_r > px) && (bx < pipe_r);
  assign hit     = (x_ov && ((by < py) || (bird_b > gap_b))) || (bird_b >= 11'(FLOOR_Y));
  assign scored  = !hit && (pipe_r <= bx) && !passed_q;
  assign respawn = (px >= bird_r);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    passed_d = passed_q;
    Start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_press) begin
          state_d  = S_PLAY;
          score_d  = 16'h0000;
          passed_d = 1'b0;
          Start    = 1'b1;
        end
      end
      S_PLAY: begin
        if (FrameTick) begin
          if (hit) begin
            state_d = S_DEAD;
          end else if (scored) begin
            score_d  = bcd_inc(score_q);
            passed_d = 1'b1;
          end
          if (respawn) passed_d = 1'b0;
        end
      end
      S_DEAD: begin
        if (start_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      score_q   <= 16'h0000;
      passed_q  <= 1'b0;
      flap_q    <= 1'b0;
      running_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      passed_q  <= passed_d;
      flap_q    <= flap_press && (state_q == S_PLAY);
      running_q <= (state_q == S_PLAY);
      lost_q    <= (state_q == S_DEAD);
    end
  end

  assign Flap    = flap_q;
  assign Running = running_q;
  assign Lost    = lost_q;
  assign Score   = score_q;
  assign State   = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a short debounce window.

module tb_game_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        BtnStart = 1'b0, BtnFlap = 1'b0, FrameTick = 1'b0;
  logic [9:0]  BirdX = 10'd100, BirdY = 10'd200, PipeX = 10'd600, PipeY = 10'd150;
  logic        Start, Flap, Running, Lost;
  logic [15:0] Score;
  logic [1:0]  State;

  int checks = 0;
  int failures = 0;

  game_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .BtnStart(BtnStart), .BtnFlap(BtnFlap),
    .FrameTick(FrameTick), .BirdX(BirdX), .BirdY(BirdY), .PipeX(PipeX), .PipeY(PipeY),
    .Start(Start), .Flap(Flap), .Running(Running), .Lost(Lost), .Score(Score), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0]  bx, by, px, py;
    logic [1:0]  st;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Holds start for hold_n cycles, releases, and counts Start cycles seen
  task automatic press_start(input int hold_n, output int nstart);
    nstart = 0;
    BtnStart = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      tick();
      if (Start) nstart++;
    end
    BtnStart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Start) nstart++;
    end
  endtask

  task automatic press_flap(input int hold_n, output int nflap);
    nflap = 0;
    BtnFlap = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      tick();
      if (Flap) nflap++;
    end
    BtnFlap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Flap) nflap++;
    end
  endtask

  task automatic frame(input logic [9:0] bx, by, px, py);
    BirdX = bx; BirdY = by; PipeX = px; PipeY = py;
    FrameTick = 1'b1;
    tick();
    FrameTick = 1'b0;
  endtask

  task automatic do_pass();
    frame(10'd100, 10'd200, 10'd40, 10'd150);
    frame(10'd100, 10'd200, 10'd600, 10'd150);
  endtask

  initial begin
    int n;
    tbl[0] = '{10'd100, 10'd200, 10'd200, 10'd150, 2'b01, 16'h0000};
    tbl[1] = '{10'd100, 10'd200, 10'd41,  10'd150, 2'b01, 16'h0000};
    tbl[2] = '{10'd100, 10'd200, 10'd40,  10'd150, 2'b01, 16'h0001};
    tbl[3] = '{10'd100, 10'd200, 10'd30,  10'd150, 2'b01, 16'h0001};
    tbl[4] = '{10'd100, 10'd200, 10'd600, 10'd150, 2'b01, 16'h0001};
    tbl[5] = '{10'd100, 10'd200, 10'd40,  10'd150, 2'b01, 16'h0002};
    tbl[6] = '{10'd100, 10'd160, 10'd90,  10'd150, 2'b01, 16'h0002};
    tbl[7] = '{10'd100, 10'd150, 10'd90,  10'd150, 2'b01, 16'h0002};
    tbl[8] = '{10'd100, 10'd250, 10'd90,  10'd150, 2'b01, 16'h0002};
    tbl[9] = '{10'd100, 10'd439, 10'd600, 10'd150, 2'b01, 16'h0002};

    repeat (3) tick();
    chk("rst_state", {14'd0, State}, 16'h0000);
    chk("rst_score", Score, 16'h0000);
    chk("rst_outs", {12'd0, Start, Flap, Running, Lost}, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // Start a game, reach 0012, then reset asynchronously mid-play
    press_start(10, n);
    chk("start1_pulses", 16'(n), 16'd1);
    chk("start1_state", {14'd0, State}, 16'h0001);
    chk("running", {15'd0, Running}, 16'h0001);
    repeat (12) do_pass();
    chk("score12", Score, 16'h0012);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_state", {14'd0, State}, 16'h0000);
    chk("async_rst_score", Score, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // Too-short start pulse is filtered
    press_start(3, n);
    chk("short_start_pulses", 16'(n), 16'd0);
    chk("short_start_state", {14'd0, State}, 16'h0000);

    press_flap(10, n);
    chk("flap_idle", 16'(n), 16'd0);

    press_start(10, n);
    chk("start2_pulses", 16'(n), 16'd1);
    chk("start2_state", {14'd0, State}, 16'h0001);
    chk("start2_score", Score, 16'h0000);

    press_flap(10, n);
    chk("flap_play", 16'(n), 16'd1);
    press_flap(100, n);
    chk("flap_hold", 16'(n), 16'd1);

    press_start(10, n);
    chk("start_in_play_pulses", 16'(n), 16'd0);
    chk("start_in_play_state", {14'd0, State}, 16'h0001);

    for (int i = 0; i < 10; i++) begin
      frame(tbl[i].bx, tbl[i].by, tbl[i].px, tbl[i].py);
      chk($sformatf("vec%0d_state", i), {14'd0, State}, {14'd0, tbl[i].st});
      chk($sformatf("vec%0d_score", i), Score, tbl[i].sc);
    end

    // Pipe collision above the gap
    frame(10'd100, 10'd140, 10'd90, 10'd150);
    chk("pipe_hit_state", {14'd0, State}, 16'h0002);
    tick();
    chk("pipe_hit_lost", {15'd0, Lost}, 16'h0001);
    chk("pipe_hit_running", {15'd0, Running}, 16'h0000);
    chk("pipe_hit_score", Score, 16'h0002);

    press_flap(10, n);
    chk("flap_dead", 16'(n), 16'd0);

    press_start(10, n);
    chk("dead_start_pulses", 16'(n), 16'd0);
    chk("dead_to_idle", {14'd0, State}, 16'h0000);
    chk("idle_score_hold", Score, 16'h0002);
    press_start(10, n);
    chk("restart_pulses", 16'(n), 16'd1);
    chk("restart_score", Score, 16'h0000);

    frame(10'd100, 10'd440, 10'd600, 10'd150);
    chk("floor_hit_state", {14'd0, State}, 16'h0002);

    press_start(10, n);
    press_start(10, n);
    chk("bcd_game_state", {14'd0, State}, 16'h0001);
    repeat (99) do_pass();
    chk("score99", Score, 16'h0099);
    do_pass();
    chk("score100", Score, 16'h0100);
    repeat (9899) do_pass();
    chk("score9999", Score, 16'h9999);
    do_pass();
    chk("score_sat", Score, 16'h9999);
    chk("sat_state", {14'd0, State}, 16'h0001);

    // Same-frame floor hit and pass: the hit wins
    frame(10'd100, 10'd440, 10'd40, 10'd150);
    press_start(10, n);
    press_start(10, n);
    do_pass();
    chk("pre_same_score", Score, 16'h0001);
    frame(10'd100, 10'd440, 10'd40, 10'd150);
    chk("same_frame_state", {14'd0, State}, 16'h0002);
    chk("same_frame_score", Score, 16'h0001);
    press_start(10, n);
    chk("same_dead_pulses", 16'(n), 16'd0);
    chk("same_dead_state", {14'd0, State}, 16'h0000);
    press_start(10, n);
    chk("same_restart_pulses", 16'(n), 16'd1);
    chk("same_restart_score", Score, 16'h0000);

    // Flap press landing on the hit frame still emits Flap
    BtnFlap = 1'b1;
    repeat (6) tick();
    frame(10'd100, 10'd440, 10'd600, 10'd150);
    chk("flap_on_hit", {15'd0, Flap}, 16'h0001);
    chk("flap_on_hit_state", {14'd0, State}, 16'h0002);
    tick();
    chk("flap_on_hit_width", {15'd0, Flap}, 16'h0000);
    BtnFlap = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
